// File: rtl/cr_kme_drbg_seed_sel_pkg.sv
// rtl/cr_kme_drbg_seed_sel_pkg.sv - shared types and constants for DRBG seed selection
package cr_kme_drbg_seed_sel_pkg;

    localparam int DRBG_CNT_W = 48;
    localparam int DRBG_KEY_W = 256;
    localparam int DRBG_VAL_W = 128;

    // A reseed interval of zero means the seed never expires.
    localparam logic [DRBG_CNT_W-1:0] RESEED_UNLIMITED = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CHECK = 2'd3
    } seed_sel_state_e;

    typedef struct packed {
        logic [255:0] key;
        logic [127:0] value;
        logic [47:0]  reseed_interval;
    } drbg_seed_t;

endpackage

// File: rtl/cr_kme_drbg_seed_cnt.sv
// rtl/cr_kme_drbg_seed_cnt.sv - per-seed generate counter, re-arm clear and expiry pulse
module cr_kme_drbg_seed_cnt
    import cr_kme_drbg_seed_sel_pkg::*;
#(
    parameter int CNT_W = DRBG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [CNT_W-1:0] interval,
    input  logic             inc,
    input  logic             check_en,
    output logic             expire,
    output logic             invalidate
);

    logic             valid_q;
    logic [CNT_W-1:0] cnt;
    logic             rise;

    assign rise = valid & ~valid_q;

    // A re-arm in the check cycle restarts the interval, so it must not also expire.
    assign expire = check_en & ~rise &
                    (interval != CNT_W'(RESEED_UNLIMITED)) & (cnt >= interval);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            cnt        <= '0;
            invalidate <= 1'b0;
        end else begin
            valid_q    <= valid;
            invalidate <= expire;
            if (rise || expire) begin
                cnt <= '0;
            end else if (inc && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cr_kme_drbg_seed_sel.sv
// rtl/cr_kme_drbg_seed_sel.sv - DRBG seed selection and reseed-interval tracking; option CR_KME_DRBG_SEED_SEL_STATS_EN
module cr_kme_drbg_seed_sel
    import cr_kme_drbg_seed_sel_pkg::*;
#(
    parameter int CNT_W = DRBG_CNT_W,
    parameter int KEY_W = DRBG_KEY_W,
    parameter int VAL_W = DRBG_VAL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed0_valid,
    input  logic [KEY_W-1:0] seed0_internal_state_key,
    input  logic [VAL_W-1:0] seed0_internal_state_value,
    input  logic [CNT_W-1:0] seed0_reseed_interval,
    input  logic             seed1_valid,
    input  logic [KEY_W-1:0] seed1_internal_state_key,
    input  logic [VAL_W-1:0] seed1_internal_state_value,
    input  logic [CNT_W-1:0] seed1_reseed_interval,
    output logic             seed0_invalidate,
    output logic             seed1_invalidate,
    input  logic             drbg_req,
    output logic             drbg_gnt,
    input  logic             drbg_done,
    output logic [KEY_W-1:0] drbg_seed_key,
    output logic [VAL_W-1:0] drbg_seed_value,
    output logic             drbg_seed_id,
`ifdef CR_KME_DRBG_SEED_SEL_STATS_EN
    output logic [31:0]      seed0_gen_total,
    output logic [31:0]      seed1_gen_total,
`endif
    output logic             drbg_no_seed
);

    seed_sel_state_e state;
    logic            active_ptr;
    logic [1:0]      seed_valid;
    drbg_seed_t      seed_s [2];
    logic            sel_ok;
    logic            sel_id;
    logic [1:0]      cnt_inc;
    logic [1:0]      cnt_check;
    logic [1:0]      cnt_expire;

    assign seed_valid = {seed1_valid, seed0_valid};

    assign seed_s[0].key             = seed0_internal_state_key;
    assign seed_s[0].value           = seed0_internal_state_value;
    assign seed_s[0].reseed_interval = seed0_reseed_interval;
    assign seed_s[1].key             = seed1_internal_state_key;
    assign seed_s[1].value           = seed1_internal_state_value;
    assign seed_s[1].reseed_interval = seed1_reseed_interval;

    // Prefer the active seed; fall back to the other one so a single valid seed still serves.
    always_comb begin
        sel_ok = 1'b1;
        sel_id = active_ptr;
        if (seed_valid[active_ptr]) begin
            sel_id = active_ptr;
        end else if (seed_valid[~active_ptr]) begin
            sel_id = ~active_ptr;
        end else begin
            sel_ok = 1'b0;
        end
    end

    assign drbg_no_seed = drbg_req & (state == ST_IDLE) & ~seed0_valid & ~seed1_valid;

    always_comb begin
        cnt_inc   = '0;
        cnt_check = '0;
        cnt_inc[drbg_seed_id]   = (state == ST_BUSY) & drbg_done;
        cnt_check[drbg_seed_id] = (state == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            active_ptr      <= 1'b0;
            drbg_gnt        <= 1'b0;
            drbg_seed_key   <= '0;
            drbg_seed_value <= '0;
            drbg_seed_id    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (drbg_req && sel_ok) begin
                        drbg_seed_key   <= seed_s[sel_id].key;
                        drbg_seed_value <= seed_s[sel_id].value;
                        drbg_seed_id    <= sel_id;
                        active_ptr      <= sel_id;
                        drbg_gnt        <= 1'b1;
                        state           <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    drbg_gnt <= 1'b0;
                    state    <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (drbg_done) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (|cnt_expire) begin
                        active_ptr <= ~active_ptr;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    cr_kme_drbg_seed_cnt #(.CNT_W(CNT_W)) u_cnt0 (
        .clk        (clk),
        .rst        (rst),
        .valid      (seed0_valid),
        .interval   (seed_s[0].reseed_interval),
        .inc        (cnt_inc[0]),
        .check_en   (cnt_check[0]),
        .expire     (cnt_expire[0]),
        .invalidate (seed0_invalidate)
    );

    cr_kme_drbg_seed_cnt #(.CNT_W(CNT_W)) u_cnt1 (
        .clk        (clk),
        .rst        (rst),
        .valid      (seed1_valid),
        .interval   (seed_s[1].reseed_interval),
        .inc        (cnt_inc[1]),
        .check_en   (cnt_check[1]),
        .expire     (cnt_expire[1]),
        .invalidate (seed1_invalidate)
    );

`ifdef CR_KME_DRBG_SEED_SEL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seed0_gen_total <= '0;
            seed1_gen_total <= '0;
        end else begin
            if (cnt_inc[0]) seed0_gen_total <= seed0_gen_total + 32'd1;
            if (cnt_inc[1]) seed1_gen_total <= seed1_gen_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cr_kme_drbg_seed_sel.sv
// tb/tb_cr_kme_drbg_seed_sel.sv - scoreboard bench for cr_kme_drbg_seed_sel
module tb_cr_kme_drbg_seed_sel;

    localparam int EV_GNT  = 0;
    localparam int EV_INV0 = 1;
    localparam int EV_INV1 = 2;

    localparam logic [255:0] K0 = {8{32'h0123_4567}};
    localparam logic [127:0] V0 = {4{32'h89ab_cdef}};
    localparam logic [255:0] K1 = {8{32'hfeed_0001}};
    localparam logic [127:0] V1 = {4{32'h1111_2222}};

    typedef struct {
        int           kind;
        logic         id;
        logic [255:0] key;
        logic [127:0] val;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed0_valid, seed1_valid;
    logic [255:0] seed0_key, seed1_key;
    logic [127:0] seed0_val, seed1_val;
    logic [47:0]  seed0_int, seed1_int;
    logic         seed0_invalidate, seed1_invalidate;
    logic         drbg_req, drbg_gnt, drbg_done;
    logic [255:0] drbg_seed_key;
    logic [127:0] drbg_seed_value;
    logic         drbg_seed_id, drbg_no_seed;
`ifdef CR_KME_DRBG_SEED_SEL_STATS_EN
    logic [31:0]  seed0_gen_total, seed1_gen_total;
`endif

    ev_t q[$];
    int  n_pass = 0;
    int  n_tot  = 0;

    always #5 clk = ~clk;

    cr_kme_drbg_seed_sel dut (
        .clk                        (clk),
        .rst                        (rst),
        .seed0_valid                (seed0_valid),
        .seed0_internal_state_key   (seed0_key),
        .seed0_internal_state_value (seed0_val),
        .seed0_reseed_interval      (seed0_int),
        .seed1_valid                (seed1_valid),
        .seed1_internal_state_key   (seed1_key),
        .seed1_internal_state_value (seed1_val),
        .seed1_reseed_interval      (seed1_int),
        .seed0_invalidate           (seed0_invalidate),
        .seed1_invalidate           (seed1_invalidate),
        .drbg_req                   (drbg_req),
        .drbg_gnt                   (drbg_gnt),
        .drbg_done                  (drbg_done),
        .drbg_seed_key              (drbg_seed_key),
        .drbg_seed_value            (drbg_seed_value),
        .drbg_seed_id               (drbg_seed_id),
`ifdef CR_KME_DRBG_SEED_SEL_STATS_EN
        .seed0_gen_total            (seed0_gen_total),
        .seed1_gen_total            (seed1_gen_total),
`endif
        .drbg_no_seed               (drbg_no_seed)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic push(input int kind, input logic id);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.key  = (kind == EV_GNT) ? (id ? K1 : K0) : '0;
        e.val  = (kind == EV_GNT) ? (id ? V1 : V0) : '0;
        q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic id, input logic [255:0] key, input logic [127:0] val);
        ev_t e;
        n_tot++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d id=%0d, expected no event", kind, id);
        end else begin
            e = q.pop_front();
            if (e.kind == kind && e.id == id && e.key == key && e.val == val) begin
                n_pass++;
            end else begin
                $display("FAIL sb_event: got kind=%0d id=%0d key=%0h val=%0h expected kind=%0d id=%0d key=%0h val=%0h",
                         kind, id, key, val, e.kind, e.id, e.key, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (drbg_gnt)         sb_check(EV_GNT, drbg_seed_id, drbg_seed_key, drbg_seed_value);
        if (seed0_invalidate) sb_check(EV_INV0, 1'b0, '0, '0);
        if (seed1_invalidate) sb_check(EV_INV1, 1'b1, '0, '0);
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // mode 0: plain generate; 1: re-arm seed0 on the completing cycle; 2: reset during BUSY
    task automatic do_gen(input logic exp_id, input logic exp_inv0, input logic exp_inv1, input int mode);
        bit got = 0;
        push(EV_GNT, exp_id);
        if (exp_inv0) push(EV_INV0, 1'b0);
        if (exp_inv1) push(EV_INV1, 1'b1);
        @(posedge clk); #1 drbg_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (drbg_gnt) begin
                got = 1;
                break;
            end
        end
        drbg_req = 1'b0;
        if (!got) begin
            chk("gnt_timeout", 1'b0, 1'b1);
            q.delete();
            return;
        end
        if (mode == 1) seed0_valid = 1'b0;
        @(posedge clk); #1 drbg_done = 1'b1;
        if (mode == 1) seed0_valid = 1'b1;
        if (mode == 2) rst = 1'b1;
        @(posedge clk); #1 drbg_done = 1'b0;
        if (mode == 2) return;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        seed0_valid = 1'b0; seed1_valid = 1'b0;
        seed0_key = K0; seed0_val = V0; seed1_key = K1; seed1_val = V1;
        seed0_int = '0; seed1_int = '0;
        drbg_req = 1'b0; drbg_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", drbg_gnt, 1'b0);
        chk("rst_inv0", seed0_invalidate, 1'b0);
        chk("rst_inv1", seed1_invalidate, 1'b0);
        chk("rst_key", drbg_seed_key, '0);
        chk("rst_val", drbg_seed_value, '0);
        chk("rst_id", drbg_seed_id, 1'b0);
        chk("rst_no_seed", drbg_no_seed, 1'b0);
        chk("rst_cnt0", dut.u_cnt0.cnt, '0);
        rst = 1'b0;

        // seed0 interval 3: expires after the third generate
        seed0_valid = 1'b1; seed0_int = 48'd3;
        do_gen(1'b0, 1'b0, 1'b0, 0);
        do_gen(1'b0, 1'b0, 1'b0, 0);
        chk("cnt0_after2", dut.u_cnt0.cnt, 48'd2);
        do_gen(1'b0, 1'b1, 1'b0, 0);
        chk("cnt0_expired", dut.u_cnt0.cnt, '0);
        seed0_valid = 1'b0;

        // interval 1 on seed0: fails over to seed1 after expiry
        do_reset();
        seed0_valid = 1'b1; seed0_int = 48'd1;
        seed1_valid = 1'b1; seed1_int = 48'd0;
        do_gen(1'b0, 1'b1, 1'b0, 0);
        seed0_valid = 1'b0;
        do_gen(1'b1, 1'b0, 1'b0, 0);

        // no seed available, then seed1 arms
        seed1_valid = 1'b0;
        @(posedge clk); #1 drbg_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_seed_high", drbg_no_seed, 1'b1);
        chk("no_seed_gnt", drbg_gnt, 1'b0);
        push(EV_GNT, 1'b1);
        seed1_valid = 1'b1;
        #1 chk("no_seed_low", drbg_no_seed, 1'b0);
        @(posedge clk); #1;
        chk("gnt_latency", drbg_gnt, 1'b1);
        drbg_req = 1'b0;
        @(posedge clk); #1 drbg_done = 1'b1;
        @(posedge clk); #1 drbg_done = 1'b0;
        @(posedge clk); #1;

        // unlimited interval
        do_reset();
        seed1_valid = 1'b0;
        seed0_valid = 1'b1; seed0_int = '0;
        for (int i = 0; i < 1000; i++) do_gen(1'b0, 1'b0, 1'b0, 0);
        chk("cnt0_1000", dut.u_cnt0.cnt, 48'd1000);

        // re-arm edge coincides with the increment: clear wins
        do_gen(1'b0, 1'b0, 1'b0, 1);
        chk("cnt0_rearm", dut.u_cnt0.cnt, '0);

        // reset while BUSY with a done that would otherwise expire seed1
        seed0_valid = 1'b0;
        seed1_valid = 1'b1; seed1_int = 48'd1;
        do_gen(1'b1, 1'b0, 1'b0, 2);
        chk("busy_rst_gnt", drbg_gnt, 1'b0);
        chk("busy_rst_inv1", seed1_invalidate, 1'b0);
        chk("busy_rst_key", drbg_seed_key, '0);
        chk("busy_rst_val", drbg_seed_value, '0);
        chk("busy_rst_id", drbg_seed_id, 1'b0);
        chk("busy_rst_cnt1", dut.u_cnt1.cnt, '0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

`ifdef CR_KME_DRBG_SEED_SEL_STATS_EN
        do_reset();
        seed1_valid = 1'b0;
        seed0_valid = 1'b1; seed0_int = '0;
        do_gen(1'b0, 1'b0, 1'b0, 0);
        do_gen(1'b0, 1'b0, 1'b0, 0);
        seed0_valid = 1'b0;
        @(posedge clk); #1 seed0_valid = 1'b1;
        for (int i = 0; i < 3; i++) do_gen(1'b0, 1'b0, 1'b0, 0);
        chk("gen_total0", seed0_gen_total, 32'd5);
        chk("gen_total1", seed1_gen_total, 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
